// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, encodings and helpers for the iterative
// multiply/divide sequencer.
//   XLEN       operand / HI / LO width
//   CNT_W      width of the CALC step counter
//   md_op_e    MULT / MULTU / DIV / DIVU encodings (op[1]=divide, op[0]=unsigned)
//   md_state_e sequencer states
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    // Two's-complement magnitude when en is set and the value is negative.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
        logic [XLEN-1:0] r;
        if (en && v[XLEN-1]) begin
            r = ~v + XLEN'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the ID/EX pipeline and the
// multiply/divide sequencer.
//   master (pipeline side): drives start, op, src_a, src_b, flush;
//                           observes busy, stall_req, done, div_by_zero, hi, lo
//   slave  (sequencer side): the mirror image
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            stall_req;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, stall_req, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, stall_req, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide loop.
//   div_mode_i  0 = shift-add multiply, 1 = restoring divide
//   acc_hi_i    multiply: partial product high word / divide: remainder
//   acc_lo_i    multiply: multiplier shifting out    / divide: dividend shifting into quotient
//   opnd_i      multiplicand / divisor (magnitude)
//   acc_hi_o, acc_lo_o  accumulator after this step
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            div_mode_i,
    input  logic [XLEN-1:0] acc_hi_i,
    input  logic [XLEN-1:0] acc_lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_hi_o,
    output logic [XLEN-1:0] acc_lo_o
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] shrem_s;
    logic [XLEN:0] diff_s;

    // Adder/subtractor and shift for a single iteration.
    always_comb begin
        sum_s   = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
        // Remainder shifted left with the next dividend bit; it is always below
        // twice the divisor, so a 33-bit difference has a valid sign bit.
        shrem_s = {acc_hi_i, acc_lo_i[XLEN-1]};
        diff_s  = shrem_s - {1'b0, opnd_i};
        if (div_mode_i) begin
            if (!diff_s[XLEN]) begin
                acc_hi_o = diff_s[XLEN-1:0];
                acc_lo_o = {acc_lo_i[XLEN-2:0], 1'b1};
            end else begin
                acc_hi_o = shrem_s[XLEN-1:0];
                acc_lo_o = {acc_lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_hi_o = sum_s[XLEN:1];
            acc_lo_o = {sum_s[0], acc_lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   muldiv_if.slave: start/op/src_a/src_b/flush in;
//         busy/stall_req/done/div_by_zero/hi/lo out
// Flow: IDLE -> PREP -> CALC (STEPS cycles) -> FIX -> DONE -> IDLE, or
// IDLE -> DONE directly for a divide by zero. HI/LO commit on FIX->DONE.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int STEPS = XLEN
)
(
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [XLEN-1:0]   step_hi_s, step_lo_s;
    logic              signed_op_s;
    logic [XLEN-1:0]   abs_a_s, abs_b_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_hi_s, fix_lo_s;

    muldiv_step u_step (
        .div_mode_i (op_q[1]),
        .acc_hi_i   (acc_hi_q),
        .acc_lo_i   (acc_lo_q),
        .opnd_i     (opnd_q),
        .acc_hi_o   (step_hi_s),
        .acc_lo_o   (step_lo_s)
    );

    // Operand magnitudes for PREP (signed ops are op[0]==0).
    always_comb begin
        signed_op_s = ~op_q[0];
        abs_a_s     = abs_if(a_q, signed_op_s);
        abs_b_s     = abs_if(b_q, signed_op_s);
    end

    // Sign correction of the unsigned result; sign flags are zero for unsigned ops.
    always_comb begin
        prod_s = {acc_hi_q, acc_lo_q};
        if (op_q[1]) begin
            fix_lo_s = neg_quo_q ? (~acc_lo_q + XLEN'(1)) : acc_lo_q;
            fix_hi_s = neg_rem_q ? (~acc_hi_q + XLEN'(1)) : acc_hi_q;
        end else begin
            if (neg_quo_q) begin
                prod_s = ~prod_s + (2*XLEN)'(1);
            end else begin
                prod_s = {acc_hi_q, acc_lo_q};
            end
            fix_hi_s = prod_s[2*XLEN-1:XLEN];
            fix_lo_s = prod_s[XLEN-1:0];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                // flush beats start
                if (!bus.flush && bus.start) begin
                    op_d = md_op_e'(bus.op);
                    a_d  = bus.src_a;
                    b_d  = bus.src_b;
                    dz_d = bus.op[1] && (bus.src_b == {XLEN{1'b0}});
                    if (bus.op[1] && (bus.src_b == {XLEN{1'b0}})) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PREP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    neg_quo_d = signed_op_s & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    neg_rem_d = signed_op_s & a_q[XLEN-1];
                    acc_hi_d  = {XLEN{1'b0}};
                    // acc_lo is seeded with the word that shifts out during CALC:
                    // the multiplier for multiply, the dividend for divide.
                    acc_lo_d  = op_q[1] ? abs_a_s : abs_b_s;
                    opnd_d    = op_q[1] ? abs_b_s : abs_a_s;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi_s;
                    acc_lo_d = step_lo_s;
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = fix_hi_s;
                    lo_d    = fix_lo_s;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MD_MULT;
            a_q       <= {XLEN{1'b0}};
            b_q       <= {XLEN{1'b0}};
            acc_hi_q  <= {XLEN{1'b0}};
            acc_lo_q  <= {XLEN{1'b0}};
            opnd_q    <= {XLEN{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Status outputs decoded from the state register; stall also covers the accept cycle.
    always_comb begin
        bus.busy        = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX);
        bus.stall_req   = bus.busy || ((state_q == ST_IDLE) && bus.start);
        bus.done        = (state_q == ST_DONE);
        bus.div_by_zero = (state_q == ST_DONE) && dz_q;
        bus.hi          = hi_q;
        bus.lo          = lo_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table-driven and randomised checks of muldiv_ctrl with a
// scoreboard queue, plus hand-written flush and reset sequences.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv_ctrl #(.STEPS(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          done_cyc;
    } vec_t;

    vec_t        scb[$];
    vec_t        tbl[11];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ch, input logic [31:0] cl);
        vec_t            r;
        longint          sa, sb2, q, rr;
        longint unsigned ua, ub, p;
        r.op = op; r.a = a; r.b = b; r.hi = ch; r.lo = cl; r.dz = 1'b0; r.done_cyc = 35;
        sa = $signed(a); sb2 = $signed(b);
        ua = {32'h0, a}; ub = {32'h0, b};
        case (op)
            2'b00: begin p = sa * sb2; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin p = ua * ub;  r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    r.dz = 1'b1; r.done_cyc = 1;
                end else if (op == 2'b10) begin
                    q = sa / sb2; rr = sa % sb2; r.lo = q[31:0]; r.hi = rr[31:0];
                end else begin
                    p = ua / ub; r.lo = p[31:0]; p = ua % ub; r.hi = p[31:0];
                end
            end
        endcase
        return r;
    endfunction

    task automatic push_exp(input vec_t e);
        scb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Drives one operation starting in cycle 0; aligned means the caller is already past the negedge.
    task automatic run_op(input logic [1:0] op_v, input logic [31:0] a, input logic [31:0] b,
                          input bit aligned, input string tag);
        int   done_cyc  = -1;
        int   stall_cnt = 0;
        vec_t e;
        for (int c = 0; c < 50; c++) begin
            if (c > 0 || !aligned) @(negedge clk);
            bus.start = (c == 0); bus.op = op_v; bus.src_a = a; bus.src_b = b; bus.flush = 1'b0;
            #1;
            if (done_cyc >= 0) begin
                chk($sformatf("%s done_one_cycle", tag), {63'h0, bus.done}, 64'h0);
                chk($sformatf("%s idle_after", tag), {63'h0, bus.busy}, 64'h0);
                break;
            end
            if (bus.stall_req) stall_cnt++;
            if (bus.done) begin
                done_cyc = c;
                if (scb.size() == 0) begin
                    chk($sformatf("%s unexpected_done", tag), 64'h1, 64'h0);
                end else begin
                    e = scb.pop_front();
                    chk($sformatf("%s hi", tag), {32'h0, bus.hi}, {32'h0, e.hi});
                    chk($sformatf("%s lo", tag), {32'h0, bus.lo}, {32'h0, e.lo});
                    chk($sformatf("%s dz", tag), {63'h0, bus.div_by_zero}, {63'h0, e.dz});
                    chk($sformatf("%s done_cycle", tag), 64'(c), 64'(e.done_cyc));
                    chk($sformatf("%s stall_cycles", tag), 64'(stall_cnt), 64'(e.done_cyc));
                end
            end
        end
        if (done_cyc < 0) begin
            chk($sformatf("%s timeout", tag), 64'h0, 64'h1);
            if (scb.size() > 0) e = scb.pop_front();
        end
    endtask

    initial begin
        vec_t e;
        bit   saw_done;
        tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 35};
        tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
        tbl[3]  = '{2'b11, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0, 35};
        tbl[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 1'b1, 1};
        tbl[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
        tbl[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
        tbl[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35};
        tbl[8]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 1'b1, 1};
        tbl[9]  = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 35};
        tbl[10] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 35};

        rst = 1'b1; bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'h0; bus.src_b = 32'h0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset hi", {32'h0, bus.hi}, 64'h0);
        chk("reset lo", {32'h0, bus.lo}, 64'h0);
        chk("reset busy", {63'h0, bus.busy}, 64'h0);
        chk("reset done", {63'h0, bus.done}, 64'h0);
        chk("reset stall", {63'h0, bus.stall_req}, 64'h0);
        chk("reset dz", {63'h0, bus.div_by_zero}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            push_exp(tbl[i]);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 10; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom);
            e = model(rop, ra, rb, m_hi, m_lo);
            push_exp(e);
            run_op(rop, ra, rb, 1'b0, $sformatf("rnd%0d", i));
        end

        // Flush in cycle 10 of a MULTU: back to IDLE in cycle 11, nothing committed.
        saw_done = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            bus.start = (c == 0); bus.op = 2'b01; bus.src_a = 32'd6; bus.src_b = 32'd7; bus.flush = (c == 10);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        chk("flush no_done", {63'h0, saw_done | bus.done}, 64'h0);
        chk("flush busy", {63'h0, bus.busy}, 64'h0);
        chk("flush hi_kept", {32'h0, bus.hi}, {32'h0, m_hi});
        chk("flush lo_kept", {32'h0, bus.lo}, {32'h0, m_lo});
        e = '{2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 35};
        push_exp(e);
        run_op(2'b01, 32'd6, 32'd7, 1'b1, "after_flush");

        // Reset in cycle 20 of a DIV, with start raised in the same cycle.
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            bus.start = (c == 0) || (c == 20); bus.op = 2'b10; bus.src_a = 32'd100; bus.src_b = 32'd7;
            rst = (c == 20);
            #1;
        end
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        #1;
        chk("rst_mid hi", {32'h0, bus.hi}, 64'h0);
        chk("rst_mid lo", {32'h0, bus.lo}, 64'h0);
        chk("rst_mid busy", {63'h0, bus.busy}, 64'h0);
        chk("rst_mid done", {63'h0, bus.done}, 64'h0);
        chk("rst_mid stall", {63'h0, bus.stall_req}, 64'h0);
        // Reset and start together in IDLE: start must be dropped.
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd9; bus.src_b = 32'd0;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        #1;
        chk("rst_start busy", {63'h0, bus.busy}, 64'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("rst_start no_done", {63'h0, saw_done}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
